// File: rtl/cache_tag_ctrl.sv
// Direct-mapped write-through L2 tag controller: hit/miss, bus requests, data-RAM fill strobes, flush sweep.
// Optional LOMEM_CACHE_EN: when defined, low-memory-page accesses are cacheable like other RAM.
module cache_tag_ctrl #(
  parameter int IDX_BITS = 10
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                REQ,
  input  logic                WR,
  input  logic [25:0]         CA,
  input  logic                CacheCS,
  input  logic                LoMemCacheCS,
  input  logic                FLUSH,
  input  logic                BUS_ACK,
  output logic                ACK,
  output logic                DSEL,
  output logic                BUS_REQ,
  output logic                DWE,
  output logic [IDX_BITS-1:0] DIDX,
  output logic                BUSY
);

  localparam int TAG_W = 26 - IDX_BITS;
  localparam int DEPTH = 1 << IDX_BITS;

  localparam logic [2:0] S_FLUSH   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_LOOKUP  = 3'd2;
  localparam logic [2:0] S_HITACK  = 3'd3;
  localparam logic [2:0] S_BUSWAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]          state;
  logic [IDX_BITS-1:0] cnt;
  logic                pend;
  logic                wr_q, cach_q, hit_q;
  logic [TAG_W-1:0]    tag_q;
  logic                cacheable;
  logic                hit;

  logic [TAG_W:0]      mem [DEPTH];
  logic [TAG_W:0]      rd_q;
  logic                t_we;
  logic [IDX_BITS-1:0] t_waddr;
  logic [TAG_W:0]      t_wdata;

`ifdef LOMEM_CACHE_EN
  logic unused_lomem;
  assign unused_lomem = LoMemCacheCS;
  assign cacheable    = CacheCS;
`else
  assign cacheable = CacheCS & ~LoMemCacheCS;
`endif

  // Entry layout {tag, valid}; read address follows CA so the lookup data is ready the cycle after accept.
  assign hit = rd_q[0] && (rd_q[TAG_W:1] == tag_q);

  always_comb begin
    t_we    = 1'b0;
    t_waddr = cnt;
    t_wdata = '0;
    if (state == S_FLUSH) begin
      t_we = 1'b1;
    end else if (state == S_BUSWAIT && BUS_ACK && cach_q && !wr_q) begin
      t_we    = 1'b1;
      t_waddr = DIDX;
      t_wdata = {tag_q, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    if (t_we) mem[t_waddr] <= t_wdata;
    rd_q <= mem[CA[IDX_BITS-1:0]];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= S_FLUSH;
      cnt     <= '0;
      pend    <= 1'b0;
      ACK     <= 1'b0;
      DSEL    <= 1'b0;
      BUS_REQ <= 1'b0;
      DWE     <= 1'b0;
      DIDX    <= '0;
      BUSY    <= 1'b1;
      wr_q    <= 1'b0;
      cach_q  <= 1'b0;
      hit_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      ACK <= 1'b0;
      DWE <= 1'b0;
      if (FLUSH && state != S_IDLE && state != S_FLUSH) pend <= 1'b1;
      case (state)
        S_FLUSH: begin
          if (FLUSH) cnt <= '0;
          else if (cnt == '1) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
        end
        S_IDLE: begin
          if (FLUSH || pend) begin
            state <= S_FLUSH;
            BUSY  <= 1'b1;
            cnt   <= '0;
            pend  <= 1'b0;
          end else if (REQ) begin
            wr_q   <= WR;
            tag_q  <= CA[25:IDX_BITS];
            cach_q <= cacheable;
            hit_q  <= 1'b0;
            DIDX   <= CA[IDX_BITS-1:0];
            if (cacheable) state <= S_LOOKUP;
            else begin
              state   <= S_BUSWAIT;
              BUS_REQ <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          hit_q <= hit;
          if (hit && !wr_q) state <= S_HITACK;
          else begin
            state   <= S_BUSWAIT;
            BUS_REQ <= 1'b1;
          end
        end
        S_HITACK: begin
          ACK   <= 1'b1;
          DSEL  <= 1'b1;
          state <= S_DONE;
        end
        S_BUSWAIT: begin
          if (BUS_ACK) begin
            BUS_REQ <= 1'b0;
            ACK     <= 1'b1;
            DSEL    <= 1'b0;
            // Read miss fills the line; write hit refreshes it; write miss does not allocate.
            DWE     <= cach_q && (!wr_q || hit_q);
            state   <= S_DONE;
          end
        end
        S_DONE: if (!REQ) state <= S_IDLE;
        default: state <= S_FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: vector table through a scoreboard queue, plus flush/reset corner sequences.
module tb_cache_tag_ctrl;

  logic        CLK = 1'b0;
  logic        nRST, REQ, WR, CacheCS, LoMemCacheCS, FLUSH, BUS_ACK;
  logic [25:0] CA;
  logic        ACK, DSEL, BUS_REQ, DWE, BUSY;
  logic [9:0]  DIDX;

  cache_tag_ctrl #(.IDX_BITS(10)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .WR(WR), .CA(CA), .CacheCS(CacheCS),
    .LoMemCacheCS(LoMemCacheCS), .FLUSH(FLUSH), .BUS_ACK(BUS_ACK),
    .ACK(ACK), .DSEL(DSEL), .BUS_REQ(BUS_REQ), .DWE(DWE), .DIDX(DIDX), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

`ifdef LOMEM_CACHE_EN
  localparam bit LOMEM = 1'b1;
`else
  localparam bit LOMEM = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [25:0] ca;
    logic        cs;
    logic        lo;
    int          dsel;
    int          dwe;
    int          bus;
    int          lat;
    int          didx;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[13];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives one CPU cycle from a negedge, answers BUS_REQ after 5 cycles, checks at ACK.
  task automatic run_txn(input vec_t v, input bit inj);
    int n, bcnt, dwes;
    bit done_;
    vec_t e;
    sbq.push_back(v);
    REQ = 1'b1; WR = v.wr; CA = v.ca; CacheCS = v.cs; LoMemCacheCS = v.lo;
    n = 0; bcnt = 0; dwes = 0; done_ = 1'b0;
    while (!done_ && n < 60) begin
      @(negedge CLK);
      n++;
      BUS_ACK = 1'b0;
      FLUSH   = 1'b0;
      if (DWE) dwes++;
      if (BUS_REQ) begin
        bcnt++;
        if (inj && bcnt == 1) FLUSH = 1'b1;
        if (bcnt == 5) BUS_ACK = 1'b1;
      end
      if (ACK) begin
        done_ = 1'b1;
        e = sbq.pop_front();
        chk("dsel", DSEL, e.dsel);
        chk("dwe_pulses", dwes, e.dwe);
        chk("bus_req_cycles", bcnt, e.bus);
        chk("ack_latency", n, e.lat);
        chk("didx", DIDX, e.didx);
        REQ = 1'b0;
      end
    end
    if (!done_) begin
      chk("ack_timeout", 0, 1);
      void'(sbq.pop_front());
      REQ = 1'b0;
    end
    @(negedge CLK);
    chk("ack_one_cycle", ACK, 0);
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (BUSY && c < 2000) begin
      c++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int c, acks, w;
    vec_t v;
    nRST = 1'b0; REQ = 1'b0; WR = 1'b0; CA = '0; CacheCS = 1'b0;
    LoMemCacheCS = 1'b0; FLUSH = 1'b0; BUS_ACK = 1'b0;

    // {wr, ca, cs, lo, dsel, dwe, bus, lat, didx}
    tbl[0]  = '{1'b0, 26'h0000400, 1'b1, 1'b0, 0, 1, 5, 7, 'h000};  // cold read miss
    tbl[1]  = '{1'b0, 26'h0000400, 1'b1, 1'b0, 1, 0, 0, 3, 'h000};  // hit
    tbl[2]  = '{1'b0, 26'h0100400, 1'b1, 1'b0, 0, 1, 5, 7, 'h000};  // same index, other tag
    tbl[3]  = '{1'b0, 26'h0000400, 1'b1, 1'b0, 0, 1, 5, 7, 'h000};  // evicted -> miss
    tbl[4]  = '{1'b1, 26'h0000400, 1'b1, 1'b0, 0, 1, 5, 7, 'h000};  // write hit, write-through
    tbl[5]  = '{1'b0, 26'h0000400, 1'b1, 1'b0, 1, 0, 0, 3, 'h000};  // tag unchanged by write
    tbl[6]  = '{1'b1, 26'h0000123, 1'b1, 1'b0, 0, 0, 5, 7, 'h123};  // write miss, no allocate
    tbl[7]  = '{1'b0, 26'h0000123, 1'b1, 1'b0, 0, 1, 5, 7, 'h123};  // so read misses
    tbl[8]  = '{1'b0, 26'h0000200, 1'b0, 1'b0, 0, 0, 5, 6, 'h200};  // non-cacheable
    tbl[9]  = '{1'b0, 26'h0000200, 1'b0, 1'b0, 0, 0, 5, 6, 'h200};  // still bus-only
    if (LOMEM) begin
      tbl[10] = '{1'b0, 26'h0000300, 1'b1, 1'b1, 0, 1, 5, 7, 'h300};
      tbl[11] = '{1'b0, 26'h0000300, 1'b1, 1'b1, 1, 0, 0, 3, 'h300};
    end else begin
      tbl[10] = '{1'b0, 26'h0000300, 1'b1, 1'b1, 0, 0, 5, 6, 'h300};
      tbl[11] = '{1'b0, 26'h0000300, 1'b1, 1'b1, 0, 0, 5, 6, 'h300};
    end
    tbl[12] = '{1'b0, 26'h0000123, 1'b1, 1'b0, 1, 0, 0, 3, 'h123};

    repeat (3) @(negedge CLK);
    chk("rst_ack", ACK, 0);
    chk("rst_dsel", DSEL, 0);
    chk("rst_bus_req", BUS_REQ, 0);
    chk("rst_dwe", DWE, 0);
    chk("rst_didx", DIDX, 0);
    chk("rst_busy", BUSY, 1);

    // Post-reset sweep with a request held for most of it.
    nRST = 1'b1; REQ = 1'b1; CA = 26'h0000400; CacheCS = 1'b1;
    c = 0; acks = 0;
    while (BUSY && c < 2000) begin
      c++;
      if (c == 1000) REQ = 1'b0;
      @(negedge CLK);
      if (ACK) acks++;
    end
    chk("reset_sweep_cycles", c, 1024);
    chk("ack_during_sweep", acks, 0);

    for (int i = 0; i < 13; i++) run_txn(tbl[i], 1'b0);

    // FLUSH during BUSWAIT: cycle completes, then a full sweep.
    v = '{1'b0, 26'h0000055, 1'b0, 1'b0, 0, 0, 5, 6, 'h055};
    run_txn(v, 1'b1);
    w = 0;
    while (!BUSY && w < 5) begin
      @(negedge CLK);
      w++;
    end
    chk("flush_busy_rise", BUSY, 1);
    count_busy(c);
    chk("flush_sweep_cycles", c, 1024);
    v = '{1'b0, 26'h0000123, 1'b1, 1'b0, 0, 1, 5, 7, 'h123};
    run_txn(v, 1'b0);

    // Reset mid bus cycle: BUS_REQ drops asynchronously, no ACK.
    REQ = 1'b1; WR = 1'b0; CA = 26'h0000077; CacheCS = 1'b0; LoMemCacheCS = 1'b0;
    w = 0;
    while (!BUS_REQ && w < 10) begin
      @(negedge CLK);
      w++;
    end
    chk("bus_req_before_reset", BUS_REQ, 1);
    #2 nRST = 1'b0;
    #1 chk("bus_req_async_drop", BUS_REQ, 0);
    chk("ack_abandoned", ACK, 0);
    REQ = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // FLUSH pulse mid-sweep restarts the counter.
    c = 0;
    while (BUSY && c < 3000) begin
      c++;
      FLUSH = (c == 100);
      @(negedge CLK);
    end
    FLUSH = 1'b0;
    chk("restart_sweep_cycles", c, 1124);

    v = '{1'b0, 26'h0000400, 1'b1, 1'b0, 0, 1, 5, 7, 'h000};
    run_txn(v, 1'b0);
    v = '{1'b0, 26'h0000400, 1'b1, 1'b0, 1, 0, 0, 3, 'h000};
    run_txn(v, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
